// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer sample capture sink.
// Holds the default sample width, the Avalon-MM register map and the bit
// positions of the STATUS, CTRL and CMD register fields.
package synth_pkg;

    localparam int unsigned DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_CMD    = 2'd3
    } reg_addr_e;

    // STATUS fields
    localparam int unsigned ST_LEVEL_MSB = 8;
    localparam int unsigned ST_EMPTY     = 9;
    localparam int unsigned ST_FULL      = 10;
    localparam int unsigned ST_OVERFLOW  = 11;
    localparam int unsigned ST_UNDERFLOW = 12;
    localparam int unsigned ST_DROP_LSB  = 16;

    // CTRL fields
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_THR_LSB = 8;
    localparam int unsigned THR_W        = 9;

    // CMD fields
    localparam int unsigned CMD_FLUSH    = 0;
    localparam int unsigned CMD_CLEAR    = 1;

endpackage

// File: rtl/sample_fifo.sv
// Ring buffer holding captured samples.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_push, i_din     push request and sample to store
//   i_pop             pop request (head advances when not empty)
//   i_flush           empty the buffer; overrides push and pop
//   o_dout            current head sample (combinational)
//   o_level           entries held, 0..DEPTH
//   o_full, o_empty   level flags
module sample_fifo #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full buffer still accepts a
    // push alongside it. Pop on empty never bypasses the incoming sample.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/sample_capture_sink.sv
// Captures an Avalon-ST sample stream into a ring buffer that a host drains
// through a small Avalon-MM register file.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   asi_snk0_valid/data/ready    sample stream sink (ready = CTRL.enable)
//   avs_s0_address/read/write    register access, read latency 1
//   avs_s0_writedata/readdata    register data
//   irq                          level interrupt: fill level >= threshold
module sample_capture_sink
    import synth_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        asi_snk0_valid,
    input  logic [31:0] asi_snk0_data,
    output logic        asi_snk0_ready,
    input  logic [1:0]  avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
    output logic        irq
);

    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;
    localparam logic [THR_W-1:0] THR_RESET = THR_W'(DEPTH / 2);

    logic              r_enable;
    logic              r_irq_en;
    logic [THR_W-1:0]  r_threshold;
    logic              r_overflow;
    logic              r_underflow;
    logic [15:0]       r_drop_cnt;
    logic [31:0]       r_readdata;
    logic              r_irq;

    logic              w_push_req;
    logic              w_pop_req;
    logic              w_flush;
    logic              w_clear;
    logic              w_ctrl_wr;
    logic              w_drop;
    logic              w_underflow;
    logic [DATA_W-1:0] w_dout;
    logic [LVL_W-1:0]  w_level;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_status;
    logic [31:0]       w_ctrl;
    logic [31:0]       w_rd_mux;
    logic              w_unused;

    assign w_unused = &{1'b0, asi_snk0_data, avs_s0_writedata};

    assign asi_snk0_ready  = r_enable;
    assign avs_s0_readdata = r_readdata;
    assign irq             = r_irq;

    assign w_push_req  = asi_snk0_valid && r_enable;
    assign w_pop_req   = avs_s0_read && (avs_s0_address == ADDR_DATA);
    assign w_underflow = w_pop_req && w_empty;
    assign w_ctrl_wr   = avs_s0_write && (avs_s0_address == ADDR_CTRL);
    assign w_flush     = avs_s0_write && (avs_s0_address == ADDR_CMD)
                         && avs_s0_writedata[CMD_FLUSH];
    assign w_clear     = avs_s0_write && (avs_s0_address == ADDR_CMD)
                         && avs_s0_writedata[CMD_CLEAR];

    // Full buffer drops only when no pop frees a slot; flush swallows the
    // push without counting it as a drop.
    assign w_drop = w_push_req && w_full && !w_pop_req && !w_flush;

    sample_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push_req),
        .i_pop   (w_pop_req),
        .i_flush (w_flush),
        .i_din   (asi_snk0_data[DATA_W-1:0]),
        .o_dout  (w_dout),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_status = '0;
        w_status[ST_LEVEL_MSB:0]       = 9'(w_level);
        w_status[ST_EMPTY]             = w_empty;
        w_status[ST_FULL]              = w_full;
        w_status[ST_OVERFLOW]          = r_overflow;
        w_status[ST_UNDERFLOW]         = r_underflow;
        w_status[ST_DROP_LSB +: 16]    = r_drop_cnt;
    end

    always_comb begin
        w_ctrl = '0;
        w_ctrl[CTRL_EN]                = r_enable;
        w_ctrl[CTRL_IRQ_EN]            = r_irq_en;
        w_ctrl[CTRL_THR_LSB +: THR_W]  = r_threshold;
    end

    always_comb begin
        w_rd_mux = '0;
        case (reg_addr_e'(avs_s0_address))
            ADDR_DATA:   w_rd_mux = w_empty ? '0 : 32'($signed(w_dout));
            ADDR_STATUS: w_rd_mux = w_status;
            ADDR_CTRL:   w_rd_mux = w_ctrl;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable    <= 1'b0;
            r_irq_en    <= 1'b0;
            r_threshold <= THR_RESET;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_drop_cnt  <= '0;
            r_readdata  <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable    <= avs_s0_writedata[CTRL_EN];
                r_irq_en    <= avs_s0_writedata[CTRL_IRQ_EN];
                r_threshold <= avs_s0_writedata[CTRL_THR_LSB +: THR_W];
            end

            // A new event in the same cycle as a clear is kept.
            if (w_drop)           r_overflow <= 1'b1;
            else if (w_clear)     r_overflow <= 1'b0;

            if (w_underflow)      r_underflow <= 1'b1;
            else if (w_clear)     r_underflow <= 1'b0;

            if (w_clear)          r_drop_cnt <= {15'd0, w_drop};
            else if (w_drop && (r_drop_cnt != '1))
                                  r_drop_cnt <= r_drop_cnt + 16'd1;

            if (avs_s0_read)      r_readdata <= w_rd_mux;

            r_irq <= r_irq_en && (r_threshold != '0)
                     && (THR_W'(w_level) >= r_threshold);
        end
    end

endmodule

// File: tb/tb_sample_capture_sink.sv
module tb_sample_capture_sink;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        ready;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    localparam int DEPTH = 64;

    always #5 clk = ~clk;

    sample_capture_sink #(.DEPTH(64), .DATA_W(24)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .asi_snk0_valid   (valid),
        .asi_snk0_data    (data),
        .asi_snk0_ready   (ready),
        .avs_s0_address   (address),
        .avs_s0_read      (read),
        .avs_s0_write     (write),
        .avs_s0_writedata (writedata),
        .avs_s0_readdata  (readdata),
        .irq              (irq)
    );

    function automatic logic [31:0] sx24(input logic [31:0] d);
        return {{8{d[23]}}, d[23:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic mm_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    // Stimulus side of the scoreboard: model accepts while below DEPTH.
    task automatic push(input logic [31:0] d);
        valid = 1'b1; data = d;
        tick();
        valid = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(sx24(d));
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) tick();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        reset_n = 1'b1;
        tick();
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0200) begin bad++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h200); end
        mm_read(2'd2, rd);
        total++; if (rd !== 32'h0000_2000) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", rd, 32'h2000); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL post_reset_ready got=%b exp=0", ready); end
    endtask

    task automatic test_sign_ext();
        logic [31:0] rd, e;
        mm_write(2'd2, 32'h0000_2001);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL enable_ready got=%b exp=1", ready); end
        push(32'h007F_FFFF);
        push(32'h0080_0000);
        push(32'h5A00_0123);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            mm_read(2'd0, rd);
            total++; if (rd !== e) begin bad++; $display("FAIL sign_ext_data%0d got=%h exp=%h", i, rd, e); end
        end
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0200) begin bad++; $display("FAIL sign_ext_status got=%h exp=%h", rd, 32'h200); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, e;
        for (int i = 0; i < 66; i++) push(32'h00A0_0000 + i);
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0002_0C40) begin bad++; $display("FAIL ovf_status got=%h exp=%h", rd, 32'h00020C40); end
        e = exp_q.pop_front();
        mm_read(2'd0, rd);
        total++; if (rd !== e) begin bad++; $display("FAIL ovf_first_pop got=%h exp=%h", rd, e); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mm_read(2'd0, rd);
            total++; if (rd !== e) begin bad++; $display("FAIL ovf_drain got=%h exp=%h", rd, e); end
        end
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0002_0A00) begin bad++; $display("FAIL ovf_sticky got=%h exp=%h", rd, 32'h00020A00); end
        mm_write(2'd3, 32'h2);
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0200) begin bad++; $display("FAIL ovf_clear got=%h exp=%h", rd, 32'h200); end
    endtask

    task automatic test_underflow_bypass();
        logic [31:0] rd, e;
        valid = 1'b1; data = 32'h0000_0010; address = 2'd0; read = 1'b1;
        tick();
        valid = 1'b0; read = 1'b0;
        exp_q.push_back(sx24(32'h10));
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL udf_readdata got=%h exp=0", readdata); end
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_1001) begin bad++; $display("FAIL udf_status got=%h exp=%h", rd, 32'h1001); end
        e = exp_q.pop_front();
        mm_read(2'd0, rd);
        total++; if (rd !== e) begin bad++; $display("FAIL udf_next_read got=%h exp=%h", rd, e); end
        mm_write(2'd3, 32'h2);
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0200) begin bad++; $display("FAIL udf_clear got=%h exp=%h", rd, 32'h200); end
    endtask

    task automatic test_back_to_back_full();
        logic [31:0] rd, e, d;
        for (int i = 0; i < 64; i++) push(32'h0080_0000 | i);
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0440) begin bad++; $display("FAIL full_status got=%h exp=%h", rd, 32'h440); end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            d = 32'h0000_4000 + i;
            valid = 1'b1; data = d; address = 2'd0; read = 1'b1;
            tick();
            valid = 1'b0; read = 1'b0;
            exp_q.push_back(sx24(d));
            total++; if (readdata !== e) begin bad++; $display("FAIL full_pushpop%0d got=%h exp=%h", i, readdata, e); end
        end
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0440) begin bad++; $display("FAIL full_no_ovf got=%h exp=%h", rd, 32'h440); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mm_read(2'd0, rd);
            total++; if (rd !== e) begin bad++; $display("FAIL wrap_drain got=%h exp=%h", rd, e); end
        end
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0200) begin bad++; $display("FAIL wrap_empty got=%h exp=%h", rd, 32'h200); end
    endtask

    task automatic test_irq();
        logic [31:0] rd, e;
        mm_write(2'd2, 32'h0000_0403);
        for (int i = 0; i < 3; i++) begin
            push(32'h0000_0100 + i);
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_low%0d got=%b exp=0", i, irq); end
        end
        push(32'h0000_0103);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_at_4th got=%b exp=0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
        e = exp_q.pop_front();
        mm_read(2'd0, rd);
        total++; if (rd !== e) begin bad++; $display("FAIL irq_pop got=%h exp=%h", rd, e); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", irq); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mm_read(2'd0, rd);
            total++; if (rd !== e) begin bad++; $display("FAIL irq_drain got=%h exp=%h", rd, e); end
        end
    endtask

    task automatic test_flush_reset();
        logic [31:0] rd;
        for (int i = 0; i < 10; i++) push(32'h0000_0200 + i);
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL fill10_irq got=%b exp=1", irq); end
        valid = 1'b1; data = 32'h0000_0055;
        address = 2'd3; writedata = 32'h1; write = 1'b1;
        tick();
        valid = 1'b0; write = 1'b0;
        exp_q.delete();
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0200) begin bad++; $display("FAIL flush_status got=%h exp=%h", rd, 32'h200); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL flush_irq got=%b exp=0", irq); end
        mm_read(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cmd_read got=%h exp=0", rd); end
        for (int i = 0; i < 5; i++) push(32'h0000_0300 + i);
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL refill_irq got=%b exp=1", irq); end
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0005) begin bad++; $display("FAIL refill_status got=%h exp=%h", rd, 32'h5); end
        valid = 1'b1; data = 32'h0000_0077;
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", ready); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL midrst_irq got=%b exp=0", irq); end
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL midrst_readdata got=%h exp=0", readdata); end
        tick();
        reset_n = 1'b1;
        valid = 1'b0;
        exp_q.delete();
        tick();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL after_rst_ready got=%b exp=0", ready); end
        mm_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0200) begin bad++; $display("FAIL after_rst_status got=%h exp=%h", rd, 32'h200); end
        mm_read(2'd2, rd);
        total++; if (rd !== 32'h0000_2000) begin bad++; $display("FAIL after_rst_ctrl got=%h exp=%h", rd, 32'h2000); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sign_ext();
        test_overflow();
        test_underflow_bypass();
        test_back_to_back_full();
        test_irq();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_capture_sink.md
SAMPLE_CAPTURE_SINK -- requirements
Module: sample_capture_sink

Interface
REQ-001 Parameter DEPTH, default 64, ring-buffer entries (power of two, 4..256).
REQ-002 Parameter DATA_W, default 24, stored sample width.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port asi_snk0_valid  input  1  Avalon-ST sink valid from synthesizer sample stream.
REQ-006 Port asi_snk0_data  input  32  sample word; bits [DATA_W-1:0] significant.
REQ-007 Port asi_snk0_ready  output  1  sink ready, readyLatency 0.
REQ-008 Port avs_s0_address  input  2  Avalon-MM register select.
REQ-009 Port avs_s0_read  input  1  MM read strobe.
REQ-010 Port avs_s0_write  input  1  MM write strobe.
REQ-011 Port avs_s0_writedata  input  32  MM write data.
REQ-012 Port avs_s0_readdata  output  32  MM read data, fixed read latency 1.
REQ-013 Port irq  output  1  level-sensitive interrupt, fill level reached threshold.

Function
REQ-014 Transfer SHALL occur on a clk edge where asi_snk0_valid and asi_snk0_ready are both 1.
REQ-015 asi_snk0_ready SHALL equal CTRL.enable (no backpressure; source cannot stall).
REQ-016 Accepted sample SHALL store asi_snk0_data[DATA_W-1:0] at write pointer; pointer wraps DEPTH-1 -> 0.
REQ-017 Transfer while full SHALL discard sample, set STATUS.overflow sticky, increment drop count (16-bit, saturates at 0xFFFF).
REQ-018 Address 0 read (DATA) SHALL pop head; readdata next cycle = head sign-extended to 32 bits.
REQ-019 DATA read while empty SHALL return 0, set STATUS.underflow sticky, leave pointers unchanged.
REQ-020 Address 1 read (STATUS): [8:0] level, [9] empty, [10] full, [11] overflow, [12] underflow, [31:16] drop count; no side effects.
REQ-021 Address 2 (CTRL) read/write: [0] enable, [1] irq_en, [16:8] threshold; unused bits read 0.
REQ-022 Address 3 write (CMD): bit0 flush (pointers and level to 0), bit1 clear overflow, underflow, drop count; reads return 0.
REQ-023 Reads of any address SHALL update readdata exactly one cycle after read strobe; otherwise readdata holds last value.
REQ-024 Simultaneous push and pop SHALL both occur; level unchanged.
REQ-025 Push while full with simultaneous pop SHALL be accepted, no overflow.
REQ-026 Pop while empty with simultaneous push: pop underflows (no bypass), push stored, level becomes 1.
REQ-027 Flush coinciding with push SHALL win: sample discarded, level 0, no overflow.
REQ-028 irq SHALL be registered: 1 when irq_en=1, threshold!=0 and level>=threshold, else 0.
REQ-029 Level SHALL be a DEPTH+1-state counter (0..DEPTH) kept consistent with pointers every cycle.
REQ-030 Simultaneous read and write strobes SHALL be treated as independent; both actions take effect.

Reset
REQ-031 reset_n low SHALL immediately clear pointers, level, stickies, drop count, readdata and irq to 0.
REQ-032 Reset SHALL set enable=0, irq_en=0, threshold=DEPTH/2; asi_snk0_ready=0 during and after reset.
REQ-033 Reset asserted mid-transfer SHALL drop that sample; buffer memory contents need not clear.

Structure
REQ-034 Shared package synth_pkg SHALL hold DATA_W default, register address constants, STATUS/CTRL bit positions.
REQ-035 Ring buffer with pointers and level SHALL be sub-module sample_fifo (push, pop, flush, dout, level, full, empty).
REQ-036 Register decode, stickies, drop counter and irq SHALL live in sample_capture_sink.

Verification
REQ-037 Reset, write CTRL=0x0000_2001, push 0x7FFFFF,0x800000,0x000123 -> DATA reads 0x007FFFFF, 0xFF800000, 0x00000123; STATUS empty=1.
REQ-038 Push 66 samples, DEPTH 64, no reads -> level 64, full=1, overflow=1, drop count 2; first pop returns sample 0.
REQ-039 Empty buffer, DATA read with same-cycle push 0x000010 -> readdata 0, underflow=1, level 1, next read 0x00000010.
REQ-040 Full buffer, push and pop same cycle -> no overflow, level 64, FIFO order preserved across pointer wrap.
REQ-041 irq_en=1, threshold 4 -> irq rises one cycle after 4th push, falls one cycle after pop to level 3.
REQ-042 Fill 10, CMD flush with same-cycle push, then reset_n pulse mid-stream -> level 0, irq 0, ready 0, readdata 0.
